// File: rtl/mem_stage.sv
// Memory-access stage of the RV32 pipeline: data-memory handshake, store lane steering,
// load alignment/extension, writeback select and the MEM/WB register.
// Optional feature macro: MEM_MISALIGN_TRAP_EN (adds mem_misalign and suppresses misaligned accesses).
module mem_stage #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PC_W-1:0]   MEM_PCtoReg,
    input  logic [DATA_W-1:0] MEM_ALUout,
    input  logic [DATA_W-1:0] MEM_forward_rs2_data,
    input  logic [4:0]        MEM_rd_addr,
    input  logic              MEM_RDsrc,
    input  logic              MEM_Memread,
    input  logic              MEM_Memwrite,
    input  logic              MEM_MemtoReg,
    input  logic              MEM_RegWrite,
    input  logic [2:0]        MEM_lw_type,
    input  logic [2:0]        MEM_sw_type,
    input  logic              dm_ready,
    input  logic              dm_rvalid,
    input  logic [DATA_W-1:0] dm_rdata,
    output logic              dm_req,
    output logic              dm_we,
    output logic [3:0]        dm_bwe,
    output logic [DATA_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_wdata,
    output logic              mem_stall,
    output logic [DATA_W-1:0] MEM_fwd_data,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic              mem_misalign,
`endif
    output logic              WB_RegWrite,
    output logic [4:0]        WB_rd_addr,
    output logic [DATA_W-1:0] WB_wdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP
    } state_t;

    state_t state, state_n;

    logic [1:0] off;
    logic       is_load, is_store, acc_raw, acc, misalign;
    logic       ld_half, ld_byte, st_half, st_byte;
    logic       store_done, load_done;

    // A simultaneous read+write is treated as a load.
    assign is_load  = MEM_Memread;
    assign is_store = MEM_Memwrite & ~MEM_Memread;
    assign acc_raw  = MEM_Memread | MEM_Memwrite;
    assign off      = MEM_ALUout[1:0];

    assign ld_half = (MEM_lw_type == 3'd1) || (MEM_lw_type == 3'd3);
    assign ld_byte = (MEM_lw_type == 3'd2) || (MEM_lw_type == 3'd4);
    assign st_half = (MEM_sw_type == 3'd1);
    assign st_byte = (MEM_sw_type == 3'd2);

`ifdef MEM_MISALIGN_TRAP_EN
    logic acc_half, acc_word;
    assign acc_half = is_load ? ld_half : st_half;
    assign acc_word = is_load ? !(ld_half || ld_byte) : !(st_half || st_byte);
    assign misalign = acc_raw & ((acc_word & (off != 2'b00)) | (acc_half & off[0]));
`else
    assign misalign = 1'b0;
`endif

    assign acc = acc_raw & ~misalign;

    // NOTE: every signal driven in an always_comb gets a default first so no latch is inferred.
    always_comb begin
        state_n = state;
        dm_req  = 1'b0;
        case (state)
            S_IDLE: begin
                if (acc) begin
                    dm_req = 1'b1;
                    if (dm_ready) state_n = is_load ? S_RESP : S_IDLE;
                    else          state_n = S_REQ;
                end
            end
            S_REQ: begin
                dm_req = 1'b1;
                if (dm_ready) state_n = is_load ? S_RESP : S_IDLE;
            end
            S_RESP: begin
                if (dm_rvalid) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    // rvalid outside RESP never completes anything, so a stale response is harmless.
    assign store_done = dm_req & dm_ready & is_store;
    assign load_done  = (state == S_RESP) & dm_rvalid;
    assign mem_stall  = acc & ~store_done & ~load_done;

    assign dm_we   = dm_req & is_store;
    assign dm_addr = {MEM_ALUout[DATA_W-1:2], 2'b00};

    always_comb begin
        dm_bwe   = 4'b1111;
        dm_wdata = MEM_forward_rs2_data;
        if (st_half) begin
            dm_bwe   = off[1] ? 4'b1100 : 4'b0011;
            dm_wdata = {(DATA_W/16){MEM_forward_rs2_data[15:0]}};
        end else if (st_byte) begin
            dm_bwe   = 4'b0001 << off;
            dm_wdata = {(DATA_W/8){MEM_forward_rs2_data[7:0]}};
        end
    end

    logic [7:0]        byte_lane;
    logic [15:0]       half_lane;
    logic [DATA_W-1:0] load_data, wb_sel;

    always_comb begin
        case (off)
            2'd0:    byte_lane = dm_rdata[7:0];
            2'd1:    byte_lane = dm_rdata[15:8];
            2'd2:    byte_lane = dm_rdata[23:16];
            default: byte_lane = dm_rdata[31:24];
        endcase
        half_lane = off[1] ? dm_rdata[31:16] : dm_rdata[15:0];
        case (MEM_lw_type)
            3'd1:    load_data = {{(DATA_W-16){half_lane[15]}}, half_lane};
            3'd2:    load_data = {{(DATA_W-8){byte_lane[7]}}, byte_lane};
            3'd3:    load_data = {{(DATA_W-16){1'b0}}, half_lane};
            3'd4:    load_data = {{(DATA_W-8){1'b0}}, byte_lane};
            default: load_data = dm_rdata;
        endcase
    end

    assign MEM_fwd_data = MEM_RDsrc ? DATA_W'(MEM_PCtoReg) : MEM_ALUout;
    assign wb_sel       = MEM_RDsrc ? DATA_W'(MEM_PCtoReg)
                                    : (MEM_MemtoReg ? load_data : MEM_ALUout);

    // A stall edge inserts a bubble; rd and data still load so WB never holds X.
    always_ff @(posedge clk) begin
        if (rst) begin
            WB_RegWrite <= 1'b0;
            WB_rd_addr  <= 5'd0;
            WB_wdata    <= '0;
        end else begin
            WB_RegWrite <= MEM_RegWrite & ~mem_stall & ~misalign;
            WB_rd_addr  <= MEM_rd_addr;
            WB_wdata    <= wb_sel;
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (rst) mem_misalign <= 1'b0;
        else     mem_misalign <= misalign;
    end
`endif

endmodule
